// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates and frame lock from VGA sync timing, with a status register bus
module vga_sync_rx #(
    parameter int CD          = 12,
    parameter int HD          = 640,
    parameter int HF          = 16,
    parameter int HB          = 48,
    parameter int HR          = 96,
    parameter int VD          = 480,
    parameter int VF          = 10,
    parameter int VB          = 33,
    parameter int VR          = 2,
    parameter int LOCK_FRAMES = 2,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [CD-1:0]        rgb,
    output logic                 px_valid,
    output logic [10:0]          px_x,
    output logic [10:0]          px_y,
    output logic [CD-1:0]        px_rgb,
    output logic                 frame_start,
    output logic                 locked,
    input  logic                 device_req_i,
    input  logic [AddrWidth-1:0] device_addr_i,
    input  logic                 device_we_i,
    input  logic [3:0]           device_be_i,
    input  logic [DataWidth-1:0] device_wdata_i,
    output logic                 device_rvalid_o,
    output logic [DataWidth-1:0] device_rdata_o
);
    typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [10:0] HT   = 11'(HD + HF + HB + HR);
    localparam logic [10:0] VT   = 11'(VD + VF + VB + VR);
    localparam logic [10:0] HOFF = 11'(HR + HB);
    localparam logic [10:0] VOFF = 11'(VR + VB);
    localparam logic [10:0] HMAX = 11'h7ff;
    localparam logic [7:0]  GOOD = 8'(LOCK_FRAMES);

    state_t               state;
    logic                 hs_d, vs_d, hbad, err;
    logic [10:0]          hcnt, vcnt, h_period, v_lines;
    logic [7:0]           good;
    logic [31:0]          frame_cnt;
    logic                 hs_fall, vs_fall, sat, h_bad_now, frame_ok, err_set, err_clr, pix;
    logic [10:0]          h_new, v_new, x, y;
    logic [1:0]           sel;
    logic [DataWidth-1:0] rd;
    logic                 unused_bus;

    assign hs_fall   = tick & hs_d & ~hsync;
    assign vs_fall   = tick & vs_d & ~vsync;
    // A falling hsync ends saturation, so it never counts as a saturated tick
    assign sat       = tick & ~hs_fall & (hcnt == HMAX);
    assign h_new     = hcnt + 11'd1;
    assign v_new     = hs_fall ? vcnt + 11'd1 : vcnt;
    assign h_bad_now = hs_fall & (h_new != HT);
    assign frame_ok  = ~hbad & ~h_bad_now & (v_new == VT);
    assign x         = hcnt - HOFF;
    assign y         = vcnt - VOFF;
    assign pix       = tick & locked & (x < 11'(HD)) & (y < 11'(VD));
    assign err_set   = (state == LOCKED) & (h_bad_now | (vs_fall & (v_new != VT)) | sat);
    assign sel       = device_addr_i[3:2];
    assign err_clr   = device_req_i & device_we_i & (sel == 2'd0) & device_be_i[0] & device_wdata_i[2];
    assign rd        = sel == 2'd0 ? DataWidth'({err, 2'(state)}) :
                       sel == 2'd1 ? DataWidth'(h_period) :
                       sel == 2'd2 ? DataWidth'(v_lines) : DataWidth'(frame_cnt);
    assign unused_bus = ^{device_addr_i[AddrWidth-1:4], device_addr_i[1:0], device_be_i[3:1],
                          device_wdata_i[DataWidth-1:3], device_wdata_i[1:0]};

    // Sync edge history, line/frame counters and the measured periods, all advanced on ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
            hcnt     <= '0;
            vcnt     <= '0;
            h_period <= '0;
            v_lines  <= '0;
            hbad     <= 1'b0;
        end else if (tick) begin
            hs_d     <= hsync;
            vs_d     <= vsync;
            hcnt     <= hs_fall ? '0 : (hcnt == HMAX ? hcnt : h_new);
            h_period <= hs_fall ? h_new : h_period;
            vcnt     <= vs_fall ? '0 : v_new;
            v_lines  <= vs_fall ? v_new : v_lines;
            hbad     <= vs_fall ? 1'b0 : hbad | h_bad_now;
        end
    end

    // Lock FSM with registered locked/frame_start and the locked-frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            good        <= '0;
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vs_fall & (state == LOCKED);
            frame_cnt   <= (vs_fall & (state == LOCKED)) ? frame_cnt + 32'd1 : frame_cnt;
            if (sat | err_set) begin
                state  <= SEARCH;
                locked <= 1'b0;
            end else if (vs_fall) begin
                if (state == SEARCH) begin
                    state <= VERIFY;
                    good  <= '0;
                end else if (state == VERIFY) begin
                    if (!frame_ok) begin
                        state <= SEARCH;
                    end else if (good + 8'd1 == GOOD) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else begin
                        good <= good + 8'd1;
                    end
                end
            end
        end
    end

    // Sticky error flag; a simultaneous set overrides a bus clear
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= err_set ? 1'b1 : (err_clr ? 1'b0 : err);
        end
    end

    // Recovered pixel output, one clk after the sampling tick
    always_ff @(posedge clk) begin
        if (reset) begin
            px_valid <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
            px_rgb   <= '0;
        end else begin
            px_valid <= pix;
            px_x     <= pix ? x : px_x;
            px_y     <= pix ? y : px_y;
            px_rgb   <= pix ? rgb : px_rgb;
        end
    end

    // Bus response: every request is answered one clk later with the addressed register
    always_ff @(posedge clk) begin
        if (reset) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_rdata_o  <= device_req_i ? rd : '0;
        end
    end
endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter CD, default 12: colour depth of rgb in bits.
REQ-002 Parameters HD/HF/HB/HR, defaults 640/16/48/96: expected horizontal display, front porch, back porch and retrace, in ticks; HT = sum = 800.
REQ-003 Parameters VD/VF/VB/VR, defaults 480/10/33/2: expected vertical timing, in lines; VT = sum = 525.
REQ-004 Parameter LOCK_FRAMES, default 2: consecutive good frames required to lock.
REQ-005 Parameters AddrWidth, DataWidth, default 32/32: bus widths.
REQ-006 clk  in  1  system clock; the only clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  pixel-rate enable; all sampling occurs only on clk edges where tick=1.
REQ-009 hsync, vsync  in  1 each  active-low sync inputs.
REQ-010 rgb  in  CD  pixel colour input.
REQ-011 px_valid  out  1  registered; high for one clk per recovered active pixel.
REQ-012 px_x, px_y  out  11 each  coordinates of the current px_valid pixel.
REQ-013 px_rgb  out  CD  colour of the current px_valid pixel.
REQ-014 frame_start  out  1  one-clk pulse at each vsync falling edge while LOCKED.
REQ-015 locked  out  1  high when FSM state = LOCKED.
REQ-016 device_req_i, device_addr_i[AddrWidth], device_we_i, device_be_i[4], device_wdata_i[DataWidth]  in  register bus request.
REQ-017 device_rvalid_o  out  1; device_rdata_o  out  DataWidth: register bus response.

Function
REQ-018 Edge detect: hs_d/vs_d registered on tick; hsync fall = tick & hs_d & ~hsync; vsync fall likewise.
REQ-019 hcnt (11 b): on hsync fall, h_period <= hcnt+1 and hcnt <= 0; on other ticks hcnt increments, saturating at 2047.
REQ-020 vcnt (11 b): increments on each hsync fall; on vsync fall, v_lines <= vcnt and vcnt <= 0; on a simultaneous hsync+vsync fall, v_lines <= vcnt+1 and vcnt <= 0.
REQ-021 Recovered coordinates: x = hcnt-(HR+HB), y = vcnt-(VR+VB), computed against the tick's pre-update counter values.
REQ-022 Pixel: a tick with locked, 0<=x<HD and 0<=y<VD shall, on the next clk edge, assert px_valid with px_x=x, px_y=y, px_rgb=rgb (1-clk latency); otherwise px_valid=0.
REQ-023 FSM SEARCH: on a vsync fall, go to VERIFY with good=0.
REQ-024 FSM VERIFY: on each vsync fall, if v_lines==VT and every h_period captured since the previous vsync fall ==HT, then good++, else go to SEARCH; when good reaches LOCK_FRAMES, go to LOCKED.
REQ-025 FSM LOCKED: any h_period!=HT, any v_lines!=VT, or hcnt saturation shall go to SEARCH and set sticky err.
REQ-026 Saturation of hcnt in any state shall force SEARCH.
REQ-027 frame_cnt (32 b) increments on each vsync fall in LOCKED and wraps at 2^32-1 to 0.
REQ-028 Register map, decoded on device_addr_i[3:2]: 0 STATUS {err[2], state[1:0]}; 1 HPERIOD; 2 VLINES; 3 FRAME_CNT. Unused bits read 0.
REQ-029 device_rvalid_o shall pulse exactly one clk after every device_req_i, for reads and writes alike; rdata shall be valid in that cycle and 0 otherwise.
REQ-030 A write to STATUS with be[0]=1 and wdata[2]=1 clears err; if a clear coincides with a set, set wins. All other writes are ignored.

Reset
REQ-031 reset shall force: state=SEARCH, hcnt=vcnt=0, h_period=v_lines=0, good=0, err=0, frame_cnt=0, hs_d=vs_d=1, and all outputs (px_*, frame_start, locked, device_rvalid_o, device_rdata_o) = 0.
REQ-032 reset asserted mid-frame or mid-bus-transaction shall abort all activity, with no pending rvalid afterward.

Verification
REQ-033 Nominal 640x480 stream on tick every 2nd clk, three frames -> locked rises at the 3rd vsync fall; thereafter exactly 307200 px_valid per frame, first pixel (0,0), last (639,479).
REQ-034 rgb = {x[5:0], y[5:0]} pattern while locked -> every px_rgb equals {px_x[5:0], px_y[5:0]}.
REQ-035 While locked, one line shortened to 799 ticks -> locked=0 by the next clk, STATUS reads err=1, state=0; after 3 good frames locked=1 again.
REQ-036 hsync held high for 2100 ticks -> hcnt saturates, state=SEARCH; HPERIOD still reads the last good value, 800.
REQ-037 Bus: read addr 0x4 after one line -> rvalid one clk later with rdata=800; read 0x8 after one frame -> 525; write 0x4 to 0x0 -> err cleared.
REQ-038 reset pulsed at pixel (320,240) while locked -> all outputs 0 the next clk; relock after 3 vsync falls.
